agc_regbank: RTL
================

Name: agc_regbank

Overview:
- Parametrised register bank that replaces the loose fixed-width per-register instances with one addressed array.
- Provides one write port, two combinational read ports, and an AGC-style counter-increment port (PINC/MINC).
- Four configurable "editing" addresses transform data on write: cycle-right, shift-right, cycle-left, and EDOP.
- Sits beside the central register / memory path of the simulator datapath.

Parameters:
WIDTH, 16, data width in bits (must be >= 8)
ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
CYR_ADDR, 4, address whose writes are rotated right by 1; value >= DEPTH disables
SR_ADDR, 5, address whose writes are arithmetic-shifted right by 1; >= DEPTH disables
CYL_ADDR, 6, address whose writes are rotated left by 1; >= DEPTH disables
EDOP_ADDR, 7, address whose writes are logically shifted right by 7; >= DEPTH disables

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
wrenable  input  1  write strobe
waddr  input  ADDR_W  write address
d  input  WIDTH  write data (before editing)
raddr_a  input  ADDR_W  read address A
qa  output  WIDTH  read data A, combinational from array
raddr_b  input  ADDR_W  read address B
qb  output  WIDTH  read data B, combinational from array
inc_en  input  1  counter increment/decrement request
inc_addr  input  ADDR_W  counter target address
inc_dir  input  1  0 = +1 (PINC), 1 = -1 (MINC)
ovf  output  1  registered one-cycle pulse: last accepted inc wrapped
inc_drop  output  1  registered one-cycle pulse: inc lost to same-address write

Behaviour:
- Reset: sampled at rising clk. Clears all DEPTH registers, ovf, and inc_drop to 0. Has priority over write and inc in the same cycle. Reset mid-operation discards any pending write or inc. Reads then return 0 combinationally.
- Write: when wrenable=1 at the edge, mem[waddr] <= edit(waddr, d). Visible on qa/qb after that edge (latency 1).
- Edit function, checked in this order; addresses not matching pass d unchanged:
  - CYR: {d[0], d[WIDTH-1:1]}
  - SR: {d[WIDTH-1], d[WIDTH-1:1]}
  - CYL: {d[WIDTH-2:0], d[WIDTH-1]}
  - EDOP: {7'b0, d[WIDTH-1:7]}
  - Colliding edit parameters are a configuration error; the first match in the order above wins.
- Increment: when inc_en=1 and not blocked, mem[inc_addr] <= mem[inc_addr] ± 1, modulo 2**WIDTH. No editing is applied, including at edit addresses.
  - ovf=1 the following cycle iff +1 from all-ones or -1 from zero; otherwise ovf=0.
- Simultaneous write and inc:
  - Different addresses: both take effect in the same edge.
  - Same address: the write wins; the inc is discarded; inc_drop=1 the following cycle and ovf=0 for that cycle.
- Pulse duration: ovf and inc_drop are each high for exactly one cycle per event and 0 otherwise. Back-to-back events give back-to-back pulses.
- Reads: qa = mem[raddr_a], qb = mem[raddr_b]. Both ports may address the same or any register, including the one being written. Without bypass, a read shows the pre-edge value.
- No X is ever driven on outputs after the first reset.

Optional Feature:
REGBANK_BYPASS_EN
- Defined: when wrenable=1 and raddr_x==waddr in the same cycle, qx returns edit(waddr, d) combinationally (write-through). Inc results are never bypassed.
- Undefined: reads always return stored array contents; a new write is visible only after the edge.

Test Plan:
1. Reset, then write 16'h0001 to addr 4 (CYR) -> qa at addr 4 = 16'h8000. Write 16'h8002 to addr 5 (SR) -> 16'hC001.
2. Write 16'h8000 to addr 6 (CYL) -> 16'h0001. Write 16'h3F80 to addr 7 (EDOP) -> 16'h007F. Write 16'h1234 to addr 2 -> unedited, 16'h1234 on both qa and qb.
3. Write 16'hFFFF to addr 3, then inc_en with inc_dir=0 -> addr 3 = 16'h0000, ovf=1 for exactly one cycle. Next, inc_dir=1 -> 16'hFFFF, ovf=1. Next, inc_dir=0 -> 16'h0000, ovf=1; any further inc from 16'h0001 -> ovf=0.
4. Same cycle: wrenable to addr 1 with d=16'h1234 and inc_en to addr 1 -> addr 1 = 16'h1234, inc_drop=1 one cycle, ovf=0. Same cycle, write addr 1 and inc addr 2 (value 16'h0005) -> 16'h1234 and 16'h0006.
5. Load nonzero values into all 8 registers, assert reset for one cycle with wrenable=1 and inc_en=1 -> all reads 0, ovf=0, inc_drop=0, no write or inc retained.
6. With REGBANK_BYPASS_EN: write 16'h0001 to addr 4 with raddr_a=4 -> qa=16'h8000 in the same cycle. Without it -> qa holds the old value until after the edge.

Source files
------------

// File: rtl/agc_regbank.sv
// AGC-style register bank: one write port with address-selected editing, two combinational
// read ports, PINC/MINC counter port. Define REGBANK_BYPASS_EN for write-through reads.
module agc_regbank #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned CYR_ADDR  = 4,
  parameter int unsigned SR_ADDR   = 5,
  parameter int unsigned CYL_ADDR  = 6,
  parameter int unsigned EDOP_ADDR = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrenable,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  d,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  qa,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  qb,
  input  logic              inc_en,
  input  logic [ADDR_W-1:0] inc_addr,
  input  logic              inc_dir,
  output logic              ovf,
  output logic              inc_drop
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam bit CyrEn  = CYR_ADDR < DEPTH;
  localparam bit SrEn   = SR_ADDR < DEPTH;
  localparam bit CylEn  = CYL_ADDR < DEPTH;
  localparam bit EdopEn = EDOP_ADDR < DEPTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             ovf_q, ovf_d;
  logic             drop_q, drop_d;
  logic [WIDTH-1:0] wr_val;
  logic [WIDTH-1:0] inc_cur, inc_val;
  logic             inc_ok, same_addr;

  // First matching edit address wins if parameters collide.
  function automatic logic [WIDTH-1:0] edit(input logic [ADDR_W-1:0] a,
                                            input logic [WIDTH-1:0]  v);
    if (CyrEn && 32'(a) == CYR_ADDR)        return {v[0], v[WIDTH-1:1]};
    else if (SrEn && 32'(a) == SR_ADDR)     return {v[WIDTH-1], v[WIDTH-1:1]};
    else if (CylEn && 32'(a) == CYL_ADDR)   return {v[WIDTH-2:0], v[WIDTH-1]};
    else if (EdopEn && 32'(a) == EDOP_ADDR) return {7'b0, v[WIDTH-1:7]};
    else                                    return v;
  endfunction

  always_comb begin
    wr_val    = edit(waddr, d);
    inc_cur   = mem_q[inc_addr];
    inc_val   = inc_dir ? inc_cur - WIDTH'(1) : inc_cur + WIDTH'(1);
    same_addr = wrenable && (waddr == inc_addr);
    inc_ok    = inc_en && !same_addr;
    drop_d    = inc_en && same_addr;
    ovf_d     = inc_ok && (inc_dir ? (inc_cur == '0) : (inc_cur == '1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ovf_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
      if (inc_ok)   mem_q[inc_addr] <= inc_val;
      if (wrenable) mem_q[waddr]    <= wr_val;
    end
  end

`ifdef REGBANK_BYPASS_EN
  // Write-through of the edited write data; counter results are never forwarded.
  always_comb begin
    qa = (wrenable && raddr_a == waddr) ? wr_val : mem_q[raddr_a];
    qb = (wrenable && raddr_b == waddr) ? wr_val : mem_q[raddr_b];
  end
`else
  always_comb begin
    qa = mem_q[raddr_a];
    qb = mem_q[raddr_b];
  end
`endif

  assign ovf      = ovf_q;
  assign inc_drop = drop_q;

endmodule
